fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Instruction-fetch and program-counter stage for the multi-cycle core. It owns the PC, the instruction register (IR) and the 4-bit status flag register. It runs the memory read handshake for each fetch and applies PC updates (increment, PC-relative branch, register-indirect branch) requested by the control unit. The IR and status outputs feed the control unit directly, and the control unit's control word and constant output `k` drive this block's PC-select and branch-offset inputs.

## Interface
- `PC_W`, default 64: PC and address width.
- `RESET_PC`, default 0: PC value loaded on reset; must be a multiple of 4.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `fetch_req`  in  1  start an instruction fetch; sampled in IDLE only.
- `pc_sel`  in  2  PC update select: 00 hold, 01 PC+4, 10 PC-relative branch, 11 register target.
- `br_wide`  in  1  offset format for `pc_sel`=10: 1 selects a 26-bit offset (sign bit `k[25]`); 0 selects a 19-bit offset (sign bit `k[18]`).
- `k`  in  32  branch offset in words, zero-extended by the constant generator.
- `reg_target`  in  PC_W  absolute branch target taken from the register file.
- `set_flags`  in  1  load `status_in` into the status register.
- `status_in`  in  4  ALU flags {V,C,N,Z}.
- `mem_rd`  out  1  instruction memory read request.
- `mem_addr`  out  PC_W  read address.
- `mem_data`  in  32  read data; valid while `mem_ready` is high.
- `mem_ready`  in  1  memory completion strobe.
- `fetch_done`  out  1  one-cycle pulse; IR holds the new instruction.
- `busy`  out  1  high in REQ and DONE.
- `IR`  out  32  instruction register.
- `ipc`  out  PC_W  address of the instruction currently held in IR.
- `pc`  out  PC_W  current PC, which is the next fetch address.
- `status`  out  4  status register.

## Operation
FSM states IDLE, REQ and DONE. All outputs are registered or decoded from state.
- **IDLE:** if `fetch_req`=1, latch `mem_addr`<=`pc` and go to REQ. Otherwise apply `pc_sel`:
  - 01: `pc`<=`pc`+4.
  - 10: `pc`<=`ipc` + (sign-extended offset << 2). The offset is `k[25:0]` when `br_wide`=1 and `k[18:0]` when `br_wide`=0. Arithmetic is modulo 2^PC_W.
  - 11: `pc`<=`reg_target` with bits [1:0] forced to 0.
  - If `fetch_req` and a non-zero `pc_sel` occur in the same cycle, the fetch wins and `pc_sel` is ignored.
- **REQ:** `mem_rd`=1 and `mem_addr` is held stable. On a cycle with `mem_ready`=1:
  - `IR`<=`mem_data`, `ipc`<=`mem_addr`, `pc`<=`mem_addr`+4, then go to DONE.
  - `pc_sel` and `fetch_req` are ignored in this state.
- **DONE:** `fetch_done`=1 for exactly one cycle, then go to IDLE unconditionally. `pc_sel` and `fetch_req` are ignored.
- **Status register:** `status`<=`status_in` whenever `set_flags`=1, in any state. It holds otherwise.
- `mem_ready` outside REQ is ignored.
- **PC wrap-around:** `pc`=2^PC_W−4 followed by an increment gives 0.

## Timing
- **Reset** (synchronous, takes priority in every state):
  - state=IDLE, `pc`=`RESET_PC`, `ipc`=`RESET_PC`, `mem_addr`=`RESET_PC`.
  - `IR`=0, `status`=0, `mem_rd`=0, `fetch_done`=0, `busy`=0.
- **Reset mid-fetch:** `mem_rd` is low in the cycle after the reset edge. A `mem_ready` arriving in that cycle is ignored.
- **Fetch latency:** with `fetch_req` sampled at edge t, `mem_rd` is high from t+1.
  - If `mem_ready` is high at edge t+1+w (w ≥ 0 wait cycles), IR updates at that edge and `fetch_done` is high for the cycle that follows.
  - Minimum `fetch_req`→`fetch_done` latency is 2 cycles.
- **PC updates in IDLE** take effect at the next edge, so a `fetch_req` in the following cycle uses the new `pc`.
- `set_flags` takes effect at the next edge. `status` reflects the new flags one cycle later.
- Back-to-back fetches: the earliest next `fetch_req` acceptance is the cycle after DONE.

## Test plan
- **Reset and first fetch:** `RESET_PC`=0x100, `fetch_req` pulse, memory returns 0x8B020020 with `mem_ready` high in the first REQ cycle. Required: `mem_addr`=0x100, `IR`=0x8B020020, `ipc`=0x100, `pc`=0x104, `fetch_done` high exactly in cycle 3.
- **Wait states:** `mem_ready` is delayed 3 cycles. Required: `mem_rd` held high for 4 cycles with `mem_addr` stable, `fetch_done` at cycle 6, and `pc_sel`=01 pulsed during REQ has no effect.
- **Relative branches:** `ipc`=0x200.
  - `br_wide`=1, `k`=0x3FFFFFE (−2). Required: `pc`=0x1F8.
  - `br_wide`=0, `k`=0x00010 (+16). Required: `pc`=0x240.
- **Register branch and increment:** `pc_sel`=11 with `reg_target`=0x1003. Required: `pc`=0x1000. Then `pc_sel`=01. Required: `pc`=0x1004. Then `pc`=0xFFFF_FFFF_FFFF_FFFC with `pc_sel`=01. Required: `pc`=0.
- **Status:** `set_flags`=1 with `status_in`=4'b0101. Required: `status`=0101. Then `set_flags`=0 with `status_in`=1111. Required: `status` stays 0101.
- **Reset in REQ:** assert `reset` during wait states while `mem_ready` rises in the same cycle. Required: `IR` unchanged at 0, `pc`=`RESET_PC`, `mem_rd`=0 next cycle, no `fetch_done`.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch / program-counter stage: owns PC, IR, ipc and the status flags,
// runs the instruction-memory read handshake and applies control-unit PC updates.
module fetch_pc_unit #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic [1:0]      pc_sel,
  input  logic            br_wide,
  input  logic [31:0]     k,
  input  logic [PC_W-1:0] reg_target,
  input  logic            set_flags,
  input  logic [3:0]      status_in,
  output logic            mem_rd,
  output logic [PC_W-1:0] mem_addr,
  input  logic [31:0]     mem_data,
  input  logic            mem_ready,
  output logic            fetch_done,
  output logic            busy,
  output logic [31:0]     IR,
  output logic [PC_W-1:0] ipc,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      status
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state, state_next;

  // Offset is in words; the constant generator zero-extends k, so the sign bit
  // depends on which branch format is in use.
  function automatic logic [PC_W-1:0] rel_target(input logic [PC_W-1:0] base,
                                                 input logic [31:0]     off_k,
                                                 input logic            wide);
    logic signed [PC_W-1:0] off;
    if (wide)
      off = {{(PC_W-26){off_k[25]}}, off_k[25:0]};
    else
      off = {{(PC_W-19){off_k[18]}}, off_k[18:0]};
    return base + (off <<< 2);
  endfunction

  logic unused_bits;
  assign unused_bits = ^{k[31:26], reg_target[1:0]};

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fetch_req) state_next = REQ;
      REQ:     if (mem_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem_rd     = (state == REQ);
  assign fetch_done = (state == DONE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= RESET_PC;
      ipc      <= RESET_PC;
      mem_addr <= RESET_PC;
      IR       <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A fetch request takes precedence over any PC update this cycle.
          if (fetch_req) begin
            mem_addr <= pc;
          end else begin
            case (pc_sel)
              2'b01:   pc <= pc + PC_W'(4);
              2'b10:   pc <= rel_target(ipc, k, br_wide);
              2'b11:   pc <= {reg_target[PC_W-1:2], 2'b00};
              default: pc <= pc;
            endcase
          end
        end
        REQ: begin
          if (mem_ready) begin
            IR  <= mem_data;
            ipc <= mem_addr;
            pc  <= mem_addr + PC_W'(4);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      status <= '0;
    else if (set_flags)
      status <= status_in;
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: PC-update vector table plus scripted fetch sequences.
module tb_fetch_pc_unit;

  localparam int          PC_W     = 64;
  localparam logic [63:0] RESET_PC = 64'h100;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            fetch_req = 1'b0;
  logic [1:0]      pc_sel = 2'b00;
  logic            br_wide = 1'b0;
  logic [31:0]     k = '0;
  logic [PC_W-1:0] reg_target = '0;
  logic            set_flags = 1'b0;
  logic [3:0]      status_in = '0;
  logic            mem_rd;
  logic [PC_W-1:0] mem_addr;
  logic [31:0]     mem_data = '0;
  logic            mem_ready = 1'b0;
  logic            fetch_done;
  logic            busy;
  logic [31:0]     IR;
  logic [PC_W-1:0] ipc;
  logic [PC_W-1:0] pc;
  logic [3:0]      status;

  fetch_pc_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset), .fetch_req(fetch_req), .pc_sel(pc_sel),
    .br_wide(br_wide), .k(k), .reg_target(reg_target), .set_flags(set_flags),
    .status_in(status_in), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ready(mem_ready), .fetch_done(fetch_done),
    .busy(busy), .IR(IR), .ipc(ipc), .pc(pc), .status(status)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  sel;
    logic        wide;
    logic [31:0] kv;
    logic [63:0] tgt;
    logic [63:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] ir;
    logic [63:0] ipc;
    logic [63:0] pc;
  } fexp_t;

  vec_t        vecs [9];
  fexp_t       sb [$];
  logic [63:0] pc_q [$];
  logic [63:0] model_pc;
  logic [31:0] model_ir;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs are changed and outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] data, input int w, input logic pulse_inc);
    fexp_t e;
    fexp_t got;
    logic [63:0] addr;
    addr = model_pc;
    e.ir = data; e.ipc = addr; e.pc = addr + 64'd4;
    sb.push_back(e);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("req_mem_rd", {63'd0, mem_rd}, 64'd1);
    chk("req_mem_addr", mem_addr, addr);
    chk("req_no_done", {63'd0, fetch_done}, 64'd0);
    chk("req_busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i < w; i++) begin
      pc_sel = pulse_inc ? 2'b01 : 2'b00;
      step();
      chk("wait_mem_rd", {63'd0, mem_rd}, 64'd1);
      chk("wait_addr_stable", mem_addr, addr);
      chk("wait_no_done", {63'd0, fetch_done}, 64'd0);
    end
    pc_sel = 2'b00;
    mem_ready = 1'b1;
    mem_data = data;
    step();
    mem_ready = 1'b0;
    mem_data = 32'h5A5A_A5A5;
    // DONE cycle: a new request here must be ignored.
    fetch_req = 1'b1;
    chk("done_pulse", {63'd0, fetch_done}, 64'd1);
    chk("done_mem_rd", {63'd0, mem_rd}, 64'd0);
    chk("done_busy", {63'd0, busy}, 64'd1);
    got = sb.pop_front();
    chk("fetch_IR", {32'd0, IR}, {32'd0, got.ir});
    chk("fetch_ipc", ipc, got.ipc);
    chk("fetch_pc", pc, got.pc);
    step();
    fetch_req = 1'b0;
    chk("after_done_low", {63'd0, fetch_done}, 64'd0);
    chk("after_done_idle", {63'd0, busy}, 64'd0);
    chk("done_req_ignored", {63'd0, mem_rd}, 64'd0);
    model_pc = got.pc;
    model_ir = got.ir;
  endtask

  initial begin
    logic [63:0] exp_pc;
    vecs[0] = '{2'b10, 1'b1, 32'h03FF_FFFE, 64'h0, 64'h1F8};
    vecs[1] = '{2'b10, 1'b0, 32'h0000_0010, 64'h0, 64'h240};
    vecs[2] = '{2'b10, 1'b0, 32'h0007_FFFF, 64'h0, 64'h1FC};
    vecs[3] = '{2'b10, 1'b1, 32'hFC00_0001, 64'h0, 64'h204};
    vecs[4] = '{2'b11, 1'b0, 32'h0, 64'h1003, 64'h1000};
    vecs[5] = '{2'b01, 1'b0, 32'h0, 64'h0, 64'h1004};
    vecs[6] = '{2'b00, 1'b1, 32'h0000_0040, 64'hFFFF, 64'h1004};
    vecs[7] = '{2'b11, 1'b0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[8] = '{2'b01, 1'b0, 32'h0, 64'h0, 64'h0};

    // Reset state
    step();
    step();
    reset = 1'b0;
    chk("rst_pc", pc, RESET_PC);
    chk("rst_ipc", ipc, RESET_PC);
    chk("rst_mem_addr", mem_addr, RESET_PC);
    chk("rst_IR", {32'd0, IR}, 64'd0);
    chk("rst_status", {60'd0, status}, 64'd0);
    chk("rst_ctrl", {61'd0, mem_rd, fetch_done, busy}, 64'd0);
    model_pc = RESET_PC;
    model_ir = '0;

    // First fetch, zero wait states
    do_fetch(32'h8B02_0020, 0, 1'b0);

    // Status register
    set_flags = 1'b1; status_in = 4'b0101;
    step();
    chk("status_set", {60'd0, status}, 64'h5);
    set_flags = 1'b0; status_in = 4'b1111;
    step();
    chk("status_hold", {60'd0, status}, 64'h5);

    // Three wait states, increment pulses during REQ ignored
    do_fetch(32'h1234_5678, 3, 1'b1);

    // mem_ready in IDLE is ignored
    mem_ready = 1'b1; mem_data = 32'hDEAD_BEEF;
    step();
    mem_ready = 1'b0;
    chk("idle_ready_IR", {32'd0, IR}, {32'd0, model_ir});
    chk("idle_ready_state", {63'd0, busy}, 64'd0);

    // Bring ipc to 0x200 for the relative-branch rows
    pc_sel = 2'b11; reg_target = 64'h200;
    step();
    pc_sel = 2'b00;
    chk("reg_pc_200", pc, 64'h200);
    model_pc = 64'h200;
    do_fetch(32'hCAFE_0001, 1, 1'b0);

    foreach (vecs[i]) begin
      pc_sel = vecs[i].sel; br_wide = vecs[i].wide;
      k = vecs[i].kv; reg_target = vecs[i].tgt;
      pc_q.push_back(vecs[i].exp_pc);
      step();
      exp_pc = pc_q.pop_front();
      chk($sformatf("vec%0d_pc", i), pc, exp_pc);
    end
    pc_sel = 2'b00;

    // Reset asserted during wait states with mem_ready rising the same cycle
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_pc = RESET_PC;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    reset = 1'b1; mem_ready = 1'b1; mem_data = 32'hDEAD_BEEF;
    step();
    reset = 1'b0;
    chk("rreq_mem_rd", {63'd0, mem_rd}, 64'd0);
    chk("rreq_IR", {32'd0, IR}, 64'd0);
    chk("rreq_pc", pc, RESET_PC);
    chk("rreq_no_done", {63'd0, fetch_done}, 64'd0);
    step();
    mem_ready = 1'b0;
    chk("rreq_IR_late", {32'd0, IR}, 64'd0);
    chk("rreq_no_done_late", {63'd0, fetch_done}, 64'd0);
    chk("rreq_idle", {62'd0, mem_rd, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
